// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and constants for the divider-sharing scheduler
package div_sched_pkg;
    localparam int DEF_W = 32;
    localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_SAT = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/div_share_sched_if.sv
// div_share_sched_if: requester, response and divider bus of the divider scheduler
interface div_share_sched_if
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W = DEF_W
);
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*W-1:0] req_dividend, req_divisor;
    logic [W-1:0] rsp_quotient, div_dividend, div_divisor, div_quotient;
    logic rsp_err, div_start, div_complete;
    modport master (
        input req_valid, req_dividend, req_divisor, rsp_ready, div_quotient, div_complete,
        output req_ready, rsp_valid, rsp_quotient, rsp_err, div_start, div_dividend, div_divisor
    );
    modport slave (
        output req_valid, req_dividend, req_divisor, rsp_ready, div_quotient, div_complete,
        input req_ready, rsp_valid, rsp_quotient, rsp_err, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_share_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request above last with wrap
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(last) + k) % NREQ]) begin
                any = 1'b1;
                idx = IW'((int'(last) + k) % NREQ);
            end
        end
        grant = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/div_share_sched.sv
// div_share_sched: time-shares one multi-cycle divider among NREQ requesters
module div_share_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W = DEF_W,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    div_share_sched_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e state_q, state_d;
    logic [IW-1:0] last_q, last_d, gnt_q, gnt_d, arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic arb_any;
    logic [W-1:0] dividend_q, dividend_d, divisor_q, divisor_d, quot_q, quot_d;
    logic [W-1:0] sel_dividend, sel_divisor;
    logic err_q, err_d;
    logic [TW-1:0] wdog_q, wdog_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req(bus.req_valid),
        .last(last_q),
        .grant(arb_grant),
        .idx(arb_idx),
        .any(arb_any)
    );

    assign sel_dividend = bus.req_dividend[int'(arb_idx) * W +: W];
    assign sel_divisor = bus.req_divisor[int'(arb_idx) * W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= IW'(NREQ - 1);
            gnt_q <= '0;
            dividend_q <= '0;
            divisor_q <= '0;
            quot_q <= '0;
            err_q <= 1'b0;
            wdog_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            dividend_q <= dividend_d;
            divisor_q <= divisor_d;
            quot_q <= quot_d;
            err_q <= err_d;
            wdog_q <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d = last_q;
        gnt_d = gnt_q;
        dividend_d = dividend_q;
        divisor_d = divisor_q;
        quot_d = quot_q;
        err_d = err_q;
        wdog_d = wdog_q;
        case (state_q)
            IDLE: if (arb_any) begin
                gnt_d = arb_idx;
                dividend_d = sel_dividend;
                divisor_d = sel_divisor;
                // Divide-by-zero saturates toward the dividend's sign and never touches the divider
                if (sel_divisor == '0) begin
                    quot_d = sel_dividend[W-1] ? W'(NEG_SAT >> (32 - W)) : W'(POS_SAT >> (32 - W));
                    err_d = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.div_complete) begin
                    quot_d = bus.div_quotient;
                    err_d = 1'b0;
                    state_d = RESP;
                end else if (wdog_d == TW'(TIMEOUT)) begin
                    quot_d = '0;
                    err_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (bus.rsp_ready[gnt_q]) begin
                last_d = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE) ? arb_grant : '0;
        bus.rsp_valid = (state_q == RESP) ? NREQ'(1) << gnt_q : '0;
        bus.rsp_quotient = quot_q;
        bus.rsp_err = err_q;
        bus.div_start = state_q == ISSUE;
        bus.div_dividend = dividend_q;
        bus.div_divisor = divisor_q;
    end
endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: directed and random checks of the divider scheduler against a behavioural model
module tb_div_share_sched;
    import div_sched_pkg::*;
    localparam int NREQ = 4;
    localparam int W = 32;
    localparam int TIMEOUT = 255;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    int last = NREQ - 1, cnt = 0, lat_cfg = 0, starts = 0;
    int lat_seen;
    logic [W-1:0] cur_q, rsp_seen;
    logic err_seen;
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    div_share_sched_if #(.NREQ(NREQ), .W(W)) bus ();
    div_share_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] divq(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] n, d;
        n = {{32{a[31]}}, a};
        d = {{32{b[31]}}, b};
        n = (n <<< 16) / d;
        return n[W-1:0];
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int from);
        for (int k = 1; k <= NREQ; k++) if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        return 0;
    endfunction

    // One clock plus the external divider: completes lat_cfg cycles after it sees start (0 = never)
    task automatic tick();
        @(posedge clk);
        #1;
        bus.div_complete = 1'b0;
        bus.div_quotient = $urandom;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                bus.div_complete = 1'b1;
                bus.div_quotient = cur_q;
            end
        end
        if (bus.div_start) begin
            starts++;
            cnt = lat_cfg;
            cur_q = divq(bus.div_dividend, bus.div_divisor);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_dividend[i*W +: W] = opa[i];
            bus.req_divisor[i*W +: W] = opb[i];
        end
    endtask

    task automatic idle_zero(input string tag);
        #1;
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_div_start"}, bus.div_start, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_rsp_quotient"}, bus.rsp_quotient, 0);
        chk({tag, "_div_dividend"}, bus.div_dividend, 0);
        chk({tag, "_div_divisor"}, bus.div_divisor, 0);
    endtask

    task automatic run_op(input int stall, input bit drop, output int g);
        int n, s0, elat;
        logic [W-1:0] eq;
        logic ee;
        logic [NREQ-1:0] oh;
        #1;
        g = pick(bus.req_valid, last);
        oh = NREQ'(1) << g;
        if (opb[g] == 0) begin
            eq = opa[g][W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ee = 1'b1;
            elat = 1;
        end else if (lat_cfg >= 1 && lat_cfg <= TIMEOUT) begin
            eq = divq(opa[g], opb[g]);
            ee = 1'b0;
            elat = lat_cfg + 2;
        end else begin
            eq = '0;
            ee = 1'b1;
            elat = TIMEOUT + 2;
        end
        chk("req_ready", bus.req_ready, oh);
        s0 = starts;
        tick();
        n = 1;
        if (drop) bus.req_valid[g] = 1'b0;
        chk("div_start", bus.div_start, opb[g] != 0);
        if (opb[g] != 0) begin
            chk("div_dividend", bus.div_dividend, opa[g]);
            chk("div_divisor", bus.div_divisor, opb[g]);
        end
        while (bus.rsp_valid == 0 && n < elat + 4) begin
            chk("busy_ready", bus.req_ready, 0);
            tick();
            n++;
        end
        lat_seen = n;
        rsp_seen = bus.rsp_quotient;
        err_seen = bus.rsp_err;
        chk("rsp_latency", n, elat);
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("rsp_quotient", bus.rsp_quotient, eq);
        chk("rsp_err", bus.rsp_err, ee);
        chk("start_count", starts - s0, opb[g] != 0);
        bus.rsp_ready = NREQ'($urandom) & ~oh;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", bus.rsp_valid, oh);
            chk("stall_quotient", bus.rsp_quotient, eq);
            chk("stall_err", bus.rsp_err, ee);
            chk("stall_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = oh | (NREQ'($urandom) & ~oh);
        tick();
        chk("rsp_clear", bus.rsp_valid, 0);
        bus.rsp_ready = '0;
        last = g;
    endtask

    initial begin
        int g;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.div_complete = 1'b0;
        bus.div_quotient = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        repeat (2) tick();
        rst = 1'b0;
        idle_zero("reset");

        for (int i = 0; i < NREQ; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom | 32'h1;
        end
        apply();
        bus.req_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            lat_cfg = $urandom_range(1, 10);
            run_op(0, 1'b0, g);
            chk("rr_order", g, (i == 1) ? 2 : (i == 2) ? 3 : 0);
        end
        bus.req_valid = '0;

        opa[1] = 32'h0006_0000;
        opb[1] = 32'h0002_0000;
        apply();
        bus.req_valid = 4'b0010;
        lat_cfg = 20;
        run_op(0, 1'b1, g);
        chk("single_grant", g, 1);
        chk("single_quot", rsp_seen, 32'h0003_0000);
        chk("single_lat", lat_seen, 22);

        opa[0] = $urandom;
        opb[0] = $urandom | 32'h1;
        opa[2] = $urandom;
        opb[2] = $urandom | 32'h1;
        apply();
        bus.req_valid = 4'b0101;
        lat_cfg = 8;
        run_op(10, 1'b1, g);
        chk("bp_grant", g, 2);
        bus.req_valid = '0;

        opa[3] = 32'hFFFF_0000;
        opb[3] = '0;
        apply();
        bus.req_valid = 4'b1000;
        run_op(0, 1'b1, g);
        chk("dbz_neg_quot", rsp_seen, 32'h8000_0000);
        opa[2] = 32'h0001_0000;
        opb[2] = '0;
        apply();
        bus.req_valid = 4'b0100;
        run_op(0, 1'b1, g);
        chk("dbz_pos_quot", rsp_seen, 32'h7FFF_FFFF);

        opa[0] = $urandom;
        opb[0] = $urandom | 32'h1;
        apply();
        bus.req_valid = 4'b0001;
        lat_cfg = 0;
        run_op(0, 1'b1, g);
        chk("timeout_err", err_seen, 1);
        chk("timeout_quot", rsp_seen, 0);
        chk("timeout_lat", lat_seen, TIMEOUT + 2);
        bus.div_complete = 1'b1;
        bus.div_quotient = 32'hDEAD_BEEF;
        tick();
        chk("spurious_valid", bus.rsp_valid, 0);
        chk("spurious_start", bus.div_start, 0);
        opa[1] = $urandom;
        opb[1] = $urandom | 32'h1;
        apply();
        bus.req_valid = 4'b0010;
        lat_cfg = 5;
        run_op(0, 1'b1, g);
        chk("after_timeout_err", err_seen, 0);

        opa[2] = $urandom;
        opb[2] = $urandom | 32'h1;
        opa[3] = $urandom;
        opb[3] = $urandom | 32'h1;
        apply();
        bus.req_valid = 4'b0100;
        lat_cfg = TIMEOUT;
        run_op(0, 1'b1, g);
        chk("edge_complete_wins", err_seen, 0);
        bus.req_valid = 4'b1000;
        lat_cfg = TIMEOUT + 1;
        run_op(0, 1'b1, g);
        chk("edge_timeout", err_seen, 1);

        bus.req_valid = 4'b1000;
        lat_cfg = 20;
        tick();
        bus.req_valid = '0;
        chk("rst_start", bus.div_start, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_zero("mid_wait_rst");
        last = NREQ - 1;
        repeat (25) begin
            tick();
            chk("post_rst_valid", bus.rsp_valid, 0);
            chk("post_rst_start", bus.div_start, 0);
        end
        opa[0] = $urandom;
        opb[0] = $urandom | 32'h1;
        apply();
        bus.req_valid = 4'b1001;
        lat_cfg = 3;
        run_op(0, 1'b1, g);
        chk("post_rst_grant", g, 0);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = $urandom;
                opb[i] = ($urandom_range(0, 6) == 0) ? '0 : $urandom;
            end
            apply();
            bus.req_valid = NREQ'($urandom_range(1, 15));
            lat_cfg = $urandom_range(1, 30);
            run_op($urandom_range(0, 3), 1'($urandom), g);
        end
        bus.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Time-shares one multi-cycle fixed-point divider among NREQ requesters, such as the rotation-angle and normalisation stages of the Jacobi eigen-solver.
- Picks one requester by round-robin and drives the divider's start/operands.
- Waits for the divider's complete pulse, then returns the quotient to the granted requester with a valid/ready handshake.
- Handles divide-by-zero without using the divider and recovers from a hung divider with a watchdog.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, operand/quotient width (divider is 32-bit)
- TIMEOUT, 255, max cycles waited for div_complete before error response

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot accept pulse to the granted requester
- req_dividend  in  NREQ*W  operand i in bits [i*W +: W]
- req_divisor  in  NREQ*W  operand i in bits [i*W +: W]
- rsp_valid  out  NREQ  one-hot, response available for requester i
- rsp_ready  in  NREQ  requester i consumes response
- rsp_quotient  out  W  result, shared by all requesters
- rsp_err  out  1  1 = divide-by-zero or timeout, qualified by rsp_valid
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  W  operand to the divider
- div_divisor  out  W  operand to the divider
- div_quotient  in  W  divider result
- div_complete  in  1  divider done pulse

Behaviour:
- Reset values:
  - req_ready, rsp_valid, div_start, rsp_err: all 0.
  - rsp_quotient, div_dividend, div_divisor: all 0.
  - state = IDLE; last_grant = NREQ-1, so requester 0 wins first; watchdog = 0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant g is the first set bit scanning from last_grant+1 upward with wrap.
  - req_ready[g]=1 combinationally for this cycle only; the operands are latched on this edge.
  - If the latched divisor is 0, go to RESP directly:
    - rsp_quotient = 0x80000000 when dividend bit W-1 = 1, else 0x7FFFFFFF.
    - rsp_err = 1.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_start=1 for exactly one cycle.
  - div_dividend and div_divisor present the latched operands and stay stable until the state leaves WAIT.
  - Next state is WAIT; watchdog clears to 0.
- WAIT:
  - The watchdog increments each cycle.
  - On div_complete: latch div_quotient into rsp_quotient, rsp_err=0, go to RESP.
  - If the watchdog reaches TIMEOUT without complete: rsp_quotient=0, rsp_err=1, go to RESP.
  - If div_complete arrives in the same cycle the watchdog reaches TIMEOUT, complete wins.
- RESP:
  - rsp_valid[g]=1 (registered) and held, with rsp_quotient/rsp_err stable, until rsp_ready[g]=1.
  - On that edge: rsp_valid clears, last_grant=g, state = IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Pipeline: no new request is accepted outside IDLE, so at most one operation is in flight.
- Latency for a normal op: accept edge (IDLE), +1 cycle ISSUE start, +N divider cycles, then rsp_valid on the cycle after div_complete.
- Latency for divide-by-zero: rsp_valid is high on the cycle after accept.
- div_complete outside WAIT, including a late complete after timeout, is ignored.
- req_valid dropping after accept has no effect; req_valid dropping before accept simply removes that requester from arbitration.
- Minimum gap between grants is one IDLE cycle after RESP, so a continuously requesting requester cannot starve others.
- rst asserted in any state: the next edge returns to the reset values.
  - The in-flight op is abandoned; no response is issued.
  - div_start is not re-issued.
- Width rules:
  - Quotient is passed unmodified; no rounding or resizing.
  - The operand slice index is g*W.

Decomposition:
- Shared package div_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - saturation constants POS_SAT=0x7FFFFFFF and NEG_SAT=0x80000000
  - default W
- One sub-module: rr_arbiter (NREQ-bit request vector plus last_grant in, one-hot grant and index out; purely combinational), reusable by other shared-resource schedulers.

Test Plan:
- Single op: requester 1 sends dividend 0x00060000, divisor 0x00020000; model divider completes after 20 cycles with 0x00030000.
  - Expect req_ready[1] pulse, then div_start one cycle later.
  - Expect rsp_valid[1] with quotient 0x00030000 and err=0, 22 cycles after accept.
- Round-robin: requesters 0, 2 and 3 all valid continuously. Expect grant order 0, 2, 3, 0, and no requester granted twice while another waits.
- Divide-by-zero:
  - Dividend 0xFFFF0000, divisor 0: expect no div_start, rsp_valid next cycle, quotient 0x80000000, err=1.
  - Dividend 0x00010000, divisor 0: expect quotient 0x7FFFFFFF.
- Timeout:
  - Divider never completes: expect rsp_err=1 and quotient 0 after TIMEOUT cycles in WAIT.
  - A later spurious div_complete is ignored and the next grant proceeds normally.
- Response back-pressure: hold rsp_ready[2]=0 for 10 cycles. Expect rsp_valid[2] and quotient stable throughout, and no new req_ready during the stall.
- Reset mid-WAIT:
  - Assert rst for 1 cycle, 5 cycles after div_start: all outputs return to 0 and no rsp_valid is issued.
  - After reset, requester 0 wins first.
